// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Registered in-order {insn, pc} buffer between fetch and decode,
//            with a single-cycle flush for redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_insn,
    input  logic [31:0]      enq_pc,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_insn,
    output logic [31:0]      deq_pc,
    output logic [PTR_W:0]   count
);

    localparam logic [31:0]    C_NOP   = 32'h0000_0013;
    localparam logic [PTR_W:0] C_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] C_EMPTY = '0;

    logic [63:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic w_enq_fire;
    logic w_deq_fire;
    logic w_not_empty;

    // Full blocks enqueue even when a dequeue happens the same cycle.
    assign enq_ready   = (r_count != C_FULL) & ~flush;
    assign w_not_empty = (r_count != C_EMPTY);
    assign deq_valid   = w_not_empty;
    assign w_enq_fire  = enq_valid & enq_ready;
    assign w_deq_fire  = w_not_empty & deq_ready;
    assign count       = r_count;

    // Empty queue presents a canonical NOP so decode never sees stale data.
    always_comb begin
        deq_insn = C_NOP;
        deq_pc   = '0;
        if (w_not_empty) begin
            deq_insn = r_mem[r_rd_ptr][63:32];
            deq_pc   = r_mem[r_rd_ptr][31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_enq_fire) begin
            r_mem[r_wr_ptr] <= {enq_insn, enq_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Registered instruction buffer between instruction fetch and the decode control unit.
- Accepts {insn, pc} pairs from fetch through a valid/ready handshake and holds them in program order. It presents the oldest entry to decode, which drains it through a second valid/ready handshake.
- Provides a single-cycle flush for branch/jump redirects.
- Decouples fetch stalls from decode/dispatch backpressure.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries (redirect from branch/jump resolution).
- enq_valid  input  1  fetch presents an instruction.
- enq_ready  output  1  queue can accept this cycle.
- enq_insn  input  32  fetched instruction word.
- enq_pc  input  32  PC of enq_insn.
- deq_valid  output  1  head entry valid for decode.
- deq_ready  input  1  decode consumes the head this cycle.
- deq_insn  output  32  head instruction word; goes to decode insn input.
- deq_pc  output  32  PC of the head entry.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Only clk and rst are fixed: one clock, synchronous active-high reset.
- Reset: rd_ptr=0, wr_ptr=0, count=0. Hence enq_ready=1, deq_valid=0, deq_insn=32'h00000013, deq_pc=0.
- Storage array is not reset.
- Handshakes:
  - enq_fire = enq_valid & enq_ready.
  - deq_fire = deq_valid & deq_ready.
  - Producer may hold enq_valid across cycles; an entry is written only on enq_fire.
- Flow signals:
  - enq_ready = (count != DEPTH) & ~flush. No pass-through write when full, even if deq_fire occurs the same cycle.
  - deq_valid = (count != 0).
- Head data:
  - deq_insn and deq_pc are driven combinationally from mem[rd_ptr] when count != 0.
  - When empty: deq_insn = 32'h00000013 (ADDI x0,x0,0 canonical NOP), deq_pc = 0. Decode therefore never sees X or stale data.
- Latency: an entry written at cycle N is visible at deq_* in cycle N+1. There is no same-cycle bypass from enq to deq.
- Pointers:
  - On enq_fire: mem[wr_ptr] <= {enq_insn, enq_pc}, then wr_ptr <= wr_ptr+1.
  - On deq_fire: rd_ptr <= rd_ptr+1.
  - Both pointers wrap modulo DEPTH through natural PTR_W overflow.
- Count:
  - count <= count + enq_fire - deq_fire.
  - Simultaneous enq_fire and deq_fire leaves count unchanged and advances both pointers.
  - This is legal at any 0 < count < DEPTH.
- Flush:
  - Priority order: rst > flush > normal operation.
  - On a flush cycle: rd_ptr <= 0, wr_ptr <= 0, count <= 0.
  - Any enq_valid that cycle is dropped (enq_ready is 0).
  - A deq_fire that same cycle is still considered consumed by decode; the queue takes no further action on it.
  - The next cycle the queue is empty and enq_ready=1.
- Boundaries:
  - Full (count==DEPTH): enq_ready=0, deq_valid=1.
  - Empty: deq_valid=0, and deq_ready is ignored.
  - deq_ready is allowed to depend combinationally on deq_insn. enq_ready must not depend on enq_valid. There are no combinational paths enq->deq.
- Assertions for the bench: count never exceeds DEPTH; deq_fire never occurs while count==0.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, then release → count=0, enq_ready=1, deq_valid=0, deq_insn=32'h00000013, deq_pc=0.
- Fill to full: deq_ready=0; enqueue 8 insns {insn=32'h00100093+k<<20, pc=32'h1000+4k}, k=0..7.
  - Required: count goes 1..8; after the 8th, enq_ready=0.
  - A 9th enq_valid is held off.
  - Head shows insn 32'h00100093, pc 32'h1000.
- Drain order: from full, set deq_ready=1 for 8 cycles → deq_pc sequence 0x1000,0x1004,...,0x101C; then deq_valid=0, count=0, deq_insn=NOP.
- Wrap-around with simultaneous ops:
  - Preload 3 entries, then run enq_valid=1 and deq_ready=1 for 20 cycles with pc incrementing by 4.
  - Required: count stays 3 throughout; output pc = input pc delayed by exactly 3 dequeues; no duplicates or gaps across pointer wrap.
- Flush mid-stream: with count=5, assert flush together with enq_valid=1 (pc=0x2000) and deq_ready=1.
  - Required next cycle: count=0, deq_valid=0, enq_ready=1.
  - Enqueue pc=0x3000 → it appears at the head one cycle later; 0x2000 never appears.
- Full with simultaneous deq: at count=8, enq_valid=1 and deq_ready=1 → enq not accepted and count=7. The next cycle enq is accepted and count=7.
